// File: rtl/neuron_backprop_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : neuron_backprop_if
//  Purpose  : Handshake and data bundle for the neuron backward-pass block.
//             master = upstream/downstream environment, slave = neuron_backprop.
//  Revision : 1.0  initial release
// ============================================================================
interface neuron_backprop_if #(
    parameter int W = 32
);
    logic         start;
    logic [W-1:0] sigma_prime;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_weight;
    logic [W-1:0] in_delta;
    logic         act_valid;
    logic         act_ready;
    logic [W-1:0] prev_activ;
    logic         grad_valid;
    logic         grad_ready;
    logic [W-1:0] grad;
    logic         grad_last;
    logic [W-1:0] delta_out;
    logic         delta_valid;
    logic         busy;

    modport master (
        output start, sigma_prime, in_valid, in_weight, in_delta,
               act_valid, prev_activ, grad_ready,
        input  in_ready, act_ready, grad_valid, grad, grad_last,
               delta_out, delta_valid, busy
    );

    modport slave (
        input  start, sigma_prime, in_valid, in_weight, in_delta,
               act_valid, prev_activ, grad_ready,
        output in_ready, act_ready, grad_valid, grad, grad_last,
               delta_out, delta_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/neuron_backprop.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : neuron_backprop
//  Purpose  : Backward pass of one neuron. Accumulates sum(w[k]*d[k]) from the
//             next layer, scales by sigma_prime to form delta (also the bias
//             gradient), then streams grad[i] = delta * a[i].
//             Optional macro BP_SATURATE_EN: W-bit reductions saturate
//             instead of wrapping. Timing is identical in both builds.
//  Revision : 1.0  initial release
// ============================================================================
module neuron_backprop #(
    parameter int N_PREV = 784,
    parameter int N_NEXT = 10,
    parameter int W      = 32,
    parameter int FRAC   = 24
) (
    input  logic               clk,
    input  logic               reset,
    neuron_backprop_if.slave   bus
);

    // Accumulator holds N_NEXT full-width products without overflow; at
    // least one guard bit is kept so the sign-extension below is never empty.
    localparam int c_EXT   = (N_NEXT > 1) ? $clog2(N_NEXT) : 1;
    localparam int c_ACC_W = 2 * W + c_EXT;
    localparam int c_K_W   = $clog2(N_NEXT + 1);
    localparam int c_I_W   = $clog2(N_PREV + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SCALE = 2'd2,
        S_GRAD  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;

    logic signed [c_ACC_W-1:0]  r_acc;
    logic        [c_K_W-1:0]    r_k;
    logic        [c_I_W-1:0]    r_i;
    logic        [W-1:0]        r_sigma;
    logic        [W-1:0]        r_delta;
    logic                       r_delta_valid;
    logic        [W-1:0]        r_grad;
    logic                       r_grad_valid;
    logic                       r_grad_last;

    logic                       w_in_fire;
    logic                       w_act_fire;
    logic                       w_grad_fire;
    logic                       w_in_ready;
    logic                       w_act_ready;

    logic signed [2*W-1:0]      w_pair_prod;
    logic signed [c_ACC_W-1:0]  w_pair_x;
    logic signed [c_ACC_W-1:0]  w_acc_sh;
    logic        [W-1:0]        w_s;
    logic signed [2*W-1:0]      w_sd_prod;
    logic signed [c_ACC_W-1:0]  w_sd_sh;
    logic        [W-1:0]        w_delta;
    logic signed [2*W-1:0]      w_ga_prod;
    logic signed [c_ACC_W-1:0]  w_ga_sh;
    logic        [W-1:0]        w_grad;

    // Reduce a wide signed value to W bits: wrap by default, clamp when the
    // saturating build is selected. Out of range means the bits above the
    // W-bit sign position are not a pure sign extension.
    function automatic logic [W-1:0] f_reduce(input logic signed [c_ACC_W-1:0] v);
`ifdef BP_SATURATE_EN
        logic [c_ACC_W-W:0] top;
        top = v[c_ACC_W-1:W-1];
        if (!(&top) && (|top))
            return v[c_ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return v[W-1:0];
    endfunction

    // Handshakes
    assign w_in_ready  = (r_state == S_ACCUM);
    assign w_act_ready = (r_state == S_GRAD) && (r_i < c_I_W'(N_PREV)) &&
                         (!r_grad_valid || bus.grad_ready);
    assign w_in_fire   = w_in_ready  && bus.in_valid;
    assign w_act_fire  = w_act_ready && bus.act_valid;
    assign w_grad_fire = r_grad_valid && bus.grad_ready;

    // Arithmetic: pair product, delta scaling and gradient product
    assign w_pair_prod = $signed(bus.in_weight) * $signed(bus.in_delta);
    assign w_pair_x    = {{c_EXT{w_pair_prod[2*W-1]}}, w_pair_prod};
    assign w_acc_sh    = r_acc >>> FRAC;
    assign w_s         = f_reduce(w_acc_sh);
    assign w_sd_prod   = $signed(w_s) * $signed(r_sigma);
    assign w_sd_sh     = {{c_EXT{w_sd_prod[2*W-1]}}, w_sd_prod} >>> FRAC;
    assign w_delta     = f_reduce(w_sd_sh);
    assign w_ga_prod   = $signed(r_delta) * $signed(bus.prev_activ);
    assign w_ga_sh     = {{c_EXT{w_ga_prod[2*W-1]}}, w_ga_prod} >>> FRAC;
    assign w_grad      = f_reduce(w_ga_sh);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_ACCUM;
            S_ACCUM: if (w_in_fire && (r_k == c_K_W'(N_NEXT - 1))) w_next_state = S_SCALE;
            S_SCALE: w_next_state = S_GRAD;
            S_GRAD:  if (w_grad_fire && r_grad_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath registers: accumulate, scale, and the gradient output stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc         <= '0;
            r_k           <= '0;
            r_i           <= '0;
            r_sigma       <= '0;
            r_delta       <= '0;
            r_delta_valid <= 1'b0;
            r_grad        <= '0;
            r_grad_valid  <= 1'b0;
            r_grad_last   <= 1'b0;
        end else begin
            r_delta_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sigma <= bus.sigma_prime;
                        r_acc   <= '0;
                        r_k     <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_in_fire) begin
                        r_acc <= r_acc + w_pair_x;
                        r_k   <= r_k + 1'b1;
                    end
                end
                S_SCALE: begin
                    r_delta       <= w_delta;
                    r_delta_valid <= 1'b1;
                    r_i           <= '0;
                end
                S_GRAD: begin
                    // A new activation replaces the output beat even when the
                    // current one is consumed in the same cycle (no bubble).
                    if (w_act_fire) begin
                        r_grad       <= w_grad;
                        r_grad_valid <= 1'b1;
                        r_grad_last  <= (r_i == c_I_W'(N_PREV - 1));
                        r_i          <= r_i + 1'b1;
                    end else if (w_grad_fire) begin
                        r_grad_valid <= 1'b0;
                        r_grad_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.act_ready   = w_act_ready;
    assign bus.grad        = r_grad;
    assign bus.grad_valid  = r_grad_valid;
    assign bus.grad_last   = r_grad_last;
    assign bus.delta_out   = r_delta;
    assign bus.delta_valid = r_delta_valid;
    assign bus.busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
